// File: rtl/mc_pkg.sv
// Shared encodings for the memory-controller command scheduler:
// DIMM command codes, request op codes, FSM states and address field layout.
package mc_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_PRE = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        OP_RD      = 2'd0,
        OP_WR      = 2'd1,
        OP_IFETCH  = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ACT  = 3'd2,
        ST_CAS  = 3'd3,
        ST_XFER = 3'd4
    } state_e;

    localparam int OP_W      = 2;
    localparam int COL_LSB   = 6;
    localparam int COL_W     = 12;
    localparam int BANK_LSB  = 18;
    localparam int BANK_W    = 3;
    localparam int ROW_LSB   = 21;
    localparam int NUM_BANKS = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mc_req_fifo.sv
// Circular request queue. Head word is presented combinationally so the
// scheduler can decode it while it stays at the head for the whole access.
module mc_req_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mc_cmd_scheduler.sv
// In-order DRAM command scheduler: queues CPU requests and walks the head
// request through PRE/ACT/CAS with per-bank open-row tracking.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | wait for a queued head; choose hit/closed/conflict path
// PRE   | PRE issued on first cycle, hold T_RP cycles total
// ACT   | ACT issued on first cycle, hold T_RCD cycles total
// CAS   | RD or WR issued for one cycle
// XFER  | data phase, T_CL+T_BURST cycles; last cycle pops the head
module mc_cmd_scheduler
    import mc_pkg::*;
#(
    parameter int ADDR_W  = 36,
    parameter int DEPTH   = 16,
    parameter int T_RP    = 3,
    parameter int T_RCD   = 3,
    parameter int T_CL    = 4,
    parameter int T_BURST = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       cmd_valid,
    output logic [2:0]                 cmd,
    output logic [2:0]                 cmd_bank,
    output logic [ADDR_W-22:0]         cmd_row,
    output logic [11:0]                cmd_col,
    output logic                       req_done,
    output logic                       q_full,
    output logic                       q_empty,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       op_err
);

    localparam int QW      = OP_W + ADDR_W - COL_LSB;
    localparam int RW      = ADDR_W - ROW_LSB;
    localparam int CNT_MAX = max3(T_RP, T_RCD, T_CL + T_BURST);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] L_RP   = CW'(T_RP - 1);
    localparam logic [CW-1:0] L_RCD  = CW'(T_RCD - 1);
    localparam logic [CW-1:0] L_XFER = CW'(T_CL + T_BURST - 1);

    logic [QW-1:0]        w_head;
    logic [OP_W-1:0]      w_head_op;
    logic [BANK_W-1:0]    w_bank;
    logic [RW-1:0]        w_row;
    logic [COL_W-1:0]     w_col;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hit;
    logic                 w_unused_addr;

    state_e               r_state;
    state_e               w_state_nx;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nx;
    cmd_e                 w_cmd;
    logic                 w_cmd_valid;
    logic                 w_done;
    logic                 r_op_err;

    logic [NUM_BANKS-1:0] r_bank_open;
    logic [RW-1:0]        r_bank_row [NUM_BANKS];

    // Byte offset within a burst is not needed by the scheduler.
    assign w_unused_addr = &{1'b0, in_addr[COL_LSB-1:0]};

    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready && (in_op != OP_ILLEGAL);

    mc_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({in_op, in_addr[ADDR_W-1:COL_LSB]}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

    assign w_head_op = w_head[QW-1 -: OP_W];
    assign w_col     = w_head[0 +: COL_W];
    assign w_bank    = w_head[BANK_LSB-COL_LSB +: BANK_W];
    assign w_row     = w_head[ROW_LSB-COL_LSB +: RW];
    assign w_hit     = r_bank_open[w_bank] && (r_bank_row[w_bank] == w_row);

    assign q_full    = w_full;
    assign q_empty   = w_empty;
    assign cmd_valid = w_cmd_valid;
    assign cmd       = w_cmd;
    assign cmd_bank  = w_bank;
    assign cmd_row   = w_row;
    assign cmd_col   = w_col;
    assign req_done  = w_done;
    assign op_err    = r_op_err;

    // Next-state, wait-counter and command decode. Commands fire on the first
    // cycle of a state, recognised by the counter still holding its load value.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_cmd       = CMD_NOP;
        w_cmd_valid = 1'b0;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (w_hit) begin
                        w_state_nx = ST_CAS;
                        w_cnt_nx   = '0;
                    end else if (r_bank_open[w_bank]) begin
                        w_state_nx = ST_PRE;
                        w_cnt_nx   = L_RP;
                    end else begin
                        w_state_nx = ST_ACT;
                        w_cnt_nx   = L_RCD;
                    end
                end
            end
            ST_PRE: begin
                if (r_cnt == L_RP) begin
                    w_cmd       = CMD_PRE;
                    w_cmd_valid = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nx = ST_ACT;
                    w_cnt_nx   = L_RCD;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            ST_ACT: begin
                if (r_cnt == L_RCD) begin
                    w_cmd       = CMD_ACT;
                    w_cmd_valid = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nx = ST_CAS;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            ST_CAS: begin
                w_cmd       = (w_head_op == OP_WR) ? CMD_WR : CMD_RD;
                w_cmd_valid = 1'b1;
                w_state_nx  = ST_XFER;
                w_cnt_nx    = L_XFER;
            end
            ST_XFER: begin
                if (r_cnt == '0) begin
                    w_pop      = 1'b1;
                    w_done     = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Bank table follows the PRE/ACT commands actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_open <= '0;
            r_bank_row  <= '{default: '0};
        end else if (w_cmd_valid) begin
            if (w_cmd == CMD_PRE) begin
                r_bank_open[w_bank] <= 1'b0;
            end else if (w_cmd == CMD_ACT) begin
                r_bank_open[w_bank] <= 1'b1;
                r_bank_row[w_bank]  <= w_row;
            end
        end
    end

    // Illegal ops are dropped at the handshake and flagged one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_err <= 1'b0;
        end else begin
            r_op_err <= in_valid && in_ready && (in_op == OP_ILLEGAL);
        end
    end

endmodule

// File: tb/tb_mc_cmd_scheduler.sv
module tb_mc_cmd_scheduler;
    import mc_pkg::*;

    localparam int ADDR_W  = 36;
    localparam int DEPTH   = 16;
    localparam int T_RP    = 3;
    localparam int T_RCD   = 3;
    localparam int T_CL    = 4;
    localparam int T_BURST = 2;
    localparam int RW      = ADDR_W - 21;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_op = 2'd0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [2:0]        cmd_bank;
    logic [RW-1:0]     cmd_row;
    logic [11:0]       cmd_col;
    logic              req_done;
    logic              q_full;
    logic              q_empty;
    logic [4:0]        q_count;
    logic              op_err;

    always #5 clk = ~clk;

    mc_cmd_scheduler #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .T_RP(T_RP), .T_RCD(T_RCD),
        .T_CL(T_CL), .T_BURST(T_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .req_done(req_done), .q_full(q_full), .q_empty(q_empty),
        .q_count(q_count), .op_err(op_err)
    );

    // kind: 0 row hit, 1 bank closed, 2 row conflict
    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        int                kind;
        logic [2:0]        bank;
        logic [RW-1:0]     row;
        logic [11:0]       col;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request into an idle scheduler and trace it to req_done.
    // Cycle 1 is the first cycle the request sits at the queue head.
    task automatic run_vec(input int i);
        logic [2:0]    seen_cmd [4];
        int            seen_cyc [4];
        logic [2:0]    exp_cmd  [4];
        int            exp_cyc  [4];
        int            exp_n;
        int            exp_done;
        int            nc = 0;
        int            done_cyc = 0;
        int            stray = 0;
        logic [2:0]    cas_cmd;
        logic [2:0]    b = '0;
        logic [RW-1:0] r = '0;
        logic [11:0]   c = '0;
        for (int j = 0; j < 4; j++) begin
            seen_cmd[j] = 3'd7;
            seen_cyc[j] = 0;
            exp_cmd[j]  = 3'd7;
            exp_cyc[j]  = 0;
        end
        cas_cmd = (vecs[i].op == OP_WR) ? CMD_WR : CMD_RD;
        case (vecs[i].kind)
            0: begin
                exp_n = 1;
                exp_cmd[0] = cas_cmd; exp_cyc[0] = 2;
            end
            1: begin
                exp_n = 2;
                exp_cmd[0] = CMD_ACT; exp_cyc[0] = 2;
                exp_cmd[1] = cas_cmd; exp_cyc[1] = 2 + T_RCD;
            end
            default: begin
                exp_n = 3;
                exp_cmd[0] = CMD_PRE; exp_cyc[0] = 2;
                exp_cmd[1] = CMD_ACT; exp_cyc[1] = 2 + T_RP;
                exp_cmd[2] = cas_cmd; exp_cyc[2] = 2 + T_RP + T_RCD;
            end
        endcase
        exp_done = exp_cyc[exp_n-1] + T_CL + T_BURST;

        in_valid = 1'b1;
        in_op    = vecs[i].op;
        in_addr  = vecs[i].addr;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (cmd_valid) begin
                if (nc < 4) begin
                    seen_cmd[nc] = cmd;
                    seen_cyc[nc] = k;
                end
                nc++;
                if (cmd == CMD_RD || cmd == CMD_WR) begin
                    b = cmd_bank; r = cmd_row; c = cmd_col;
                end
            end else if (cmd != CMD_NOP) begin
                stray++;
            end
            if (req_done) begin
                done_cyc = k;
                break;
            end
        end
        check($sformatf("v%0d ncmd", i), nc, exp_n);
        for (int j = 0; j < exp_n; j++) begin
            check($sformatf("v%0d cmd%0d", i, j), seen_cmd[j], exp_cmd[j]);
            check($sformatf("v%0d cyc%0d", i, j), seen_cyc[j], exp_cyc[j]);
        end
        check($sformatf("v%0d bank", i), b, vecs[i].bank);
        check($sformatf("v%0d row", i), r, vecs[i].row);
        check($sformatf("v%0d col", i), c, vecs[i].col);
        check($sformatf("v%0d done_cyc", i), done_cyc, exp_done);
        check($sformatf("v%0d nop_idle", i), stray, 0);
        @(negedge clk);
        check($sformatf("v%0d q_count_after", i), q_count, 0);
    endtask

    // Back-to-back pushes of row-hit reads until 20 are accepted; queue fills.
    task automatic full_test();
        int mcount = 0, pushed = 0, ndone = 0, last_done = 0;
        int bad_cnt = 0, bad_full = 0, bad_rdy = 0, bad_cmd = 0, bad_space = 0;
        int max_cnt = 0;
        bit full_seen = 0, held_seen = 0;
        bit acc;
        in_op    = OP_RD;
        in_addr  = 36'h0_0020_0000;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && ndone < 20; cyc++) begin
            if (q_count != mcount) bad_cnt++;
            if (q_full != (mcount == DEPTH)) bad_full++;
            if (in_ready != (mcount < DEPTH)) bad_rdy++;
            if (q_full) full_seen = 1;
            if (int'(q_count) > max_cnt) max_cnt = int'(q_count);
            if (cmd_valid && (cmd == CMD_ACT || cmd == CMD_PRE)) bad_cmd++;
            if (req_done) begin
                if (ndone > 0 && (cyc - last_done) != 2 + T_CL + T_BURST) bad_space++;
                last_done = cyc;
                ndone++;
            end
            acc = in_valid && (mcount < DEPTH);
            if (in_valid && !acc) held_seen = 1;
            mcount = mcount + int'(acc) - int'(req_done);
            @(negedge clk);
            if (acc) begin
                pushed++;
                if (pushed == 20) in_valid = 1'b0;
                else in_addr = 36'h0_0020_0000 | (ADDR_W'(pushed) << 6);
            end
        end
        in_valid = 1'b0;
        check("full pushed", pushed, 20);
        check("full done", ndone, 20);
        check("full q_count_track", bad_cnt, 0);
        check("full q_full_track", bad_full, 0);
        check("full in_ready_track", bad_rdy, 0);
        check("full max_count", max_cnt, DEPTH);
        check("full seen", full_seen, 1);
        check("full held", held_seen, 1);
        check("full no_act_pre", bad_cmd, 0);
        check("full done_spacing", bad_space, 0);
        check("full q_empty_end", q_empty, 1);
    endtask

    initial begin
        int  bad;
        bit  found;
        vecs[0] = '{OP_RD,     36'h0_0000_0040, 1, 3'd0, RW'(0),      12'h001};
        vecs[1] = '{OP_RD,     36'h0_0000_0080, 0, 3'd0, RW'(0),      12'h002};
        vecs[2] = '{OP_WR,     36'h0_0020_0000, 2, 3'd0, RW'(1),      12'h000};
        vecs[3] = '{OP_IFETCH, 36'h0_00AD_FFC0, 1, 3'd3, RW'(5),      12'h7FF};
        vecs[4] = '{OP_WR,     36'h0_00AC_0040, 0, 3'd3, RW'(5),      12'h001};
        vecs[5] = '{OP_RD,     36'hF_FFFF_FFC0, 1, 3'd7, RW'(16'h7FFF), 12'hFFF};
        vecs[6] = '{OP_RD,     36'h0_0020_00C0, 0, 3'd0, RW'(1),      12'h003};
        vecs[7] = '{OP_RD,     36'h0_0000_0040, 1, 3'd0, RW'(0),      12'h001};

        // reset state
        #2;
        check("rst q_count", q_count, 0);
        check("rst q_empty", q_empty, 1);
        check("rst q_full", q_full, 0);
        check("rst in_ready", in_ready, 1);
        check("rst cmd_valid", cmd_valid, 0);
        check("rst cmd", cmd, CMD_NOP);
        check("rst req_done", req_done, 0);
        check("rst op_err", op_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i);

        full_test();

        // illegal op is dropped and flagged
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ILLEGAL; in_addr = 36'h0_0000_0040;
        @(negedge clk);
        in_valid = 1'b0; in_op = OP_RD;
        check("ill op_err", op_err, 1);
        check("ill q_count", q_count, 0);
        bad = 0;
        @(negedge clk);
        check("ill op_err_clear", op_err, 0);
        for (int k = 0; k < 6; k++) begin
            if (cmd_valid || q_count != 0) bad++;
            @(negedge clk);
        end
        check("ill no_cmd", bad, 0);

        // reset during XFER with 5 queued (bank 2 is closed)
        in_valid = 1'b1; in_op = OP_RD; in_addr = 36'h0_0008_0000;
        for (int j = 1; j < 5; j++) begin
            @(negedge clk);
            in_addr = 36'h0_0008_0000 | (ADDR_W'(j) << 6);
        end
        @(negedge clk);
        in_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (cmd_valid && cmd == CMD_RD) found = 1;
            else @(negedge clk);
        end
        check("rstx cas_found", found, 1);
        check("rstx q_count_pre", q_count, 5);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstx q_count", q_count, 0);
        check("rstx q_empty", q_empty, 1);
        check("rstx q_full", q_full, 0);
        check("rstx in_ready", in_ready, 1);
        check("rstx cmd_valid", cmd_valid, 0);
        check("rstx cmd", cmd, CMD_NOP);
        check("rstx req_done", req_done, 0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (cmd_valid || req_done) bad++;
        end
        check("rstx quiet", bad, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cmd_valid || req_done || !q_empty) bad++;
        end
        check("rstx no_resume", bad, 0);

        // bank 0 was open before reset; must be ACTivated again
        run_vec(7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
